// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a 16x16 simple dual-port RAM. Owns pointers,
// occupancy and flags; never issues a RAM read and write in the same cycle.
module ram_fifo_ctrl #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4,
    parameter int A_MAX   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [A_WIDTH:0]   count,
    output logic               full,
    output logic               empty,
    output logic               ram_en_write,
    output logic [A_WIDTH-1:0] ram_address_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic               ram_write_enable,
    output logic               ram_en_read,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read
);

    typedef enum logic {
        PRIO_READ  = 1'b0,
        PRIO_WRITE = 1'b1
    } prio_t;

    localparam logic [A_WIDTH:0] FULL_COUNT = (A_WIDTH + 1)'(A_MAX);

    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] rd_ptr;
    logic [A_WIDTH:0]   count_q;
    logic               out_valid_q;
    prio_t              prio;
    prio_t              prio_next;

    logic rd_req;
    logic rd_issue;
    logic wr_en;
    logic conflict;

    // Arbitration: the side holding prio wins a conflict; the loser gets prio next.
    always_comb begin
        full     = (count_q == FULL_COUNT);
        rd_req   = (count_q != '0) && (!out_valid_q || out_ready);
        rd_issue = rd_req && (!in_valid || full || prio == PRIO_READ);
        in_ready = !full && !(rd_req && prio == PRIO_READ);
        wr_en    = in_valid && in_ready;
        conflict = in_valid && !full && rd_req;
    end

    always_comb begin
        prio_next = prio;
        if (conflict) begin
            prio_next = (prio == PRIO_READ) ? PRIO_WRITE : PRIO_READ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= PRIO_READ;
        end else begin
            prio <= prio_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_issue})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (rd_issue) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid         = out_valid_q;
        out_data          = ram_data_read;
        count             = count_q;
        empty             = (count_q == '0) && !out_valid_q;
        ram_en_write      = wr_en;
        ram_write_enable  = wr_en;
        ram_address_write = wr_ptr;
        ram_data_write    = in_data;
        ram_en_read       = rd_issue;
        ram_address_read  = rd_ptr;
    end

endmodule
